i2c_write_ctrl: RTL
===================

Name: i2c_write_ctrl

Overview:
Single-master I2C write sequencer. It performs a one-byte write transaction: START, 7-bit address plus W bit, ACK, data byte, ACK, STOP. It generates SCL and open-drain SDA from an internal quarter-period tick, with the same role in the I2C subsystem as the standalone clock divider. Host logic issues a request with a START pulse and gets back DONE/ACK_ERR.

Parameters:
CLK_DIV, 250, REF_CLK cycles per quarter SCL period (SCL period = 4*CLK_DIV); legal range >= 2.

Ports:
REF_CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
START  in  1  request pulse; sampled only while idle
ADDR  in  7  target address; latched on accept
DATA  in  8  write byte; latched on accept
SDA_IN  in  1  sampled SDA line (pad input)
SCL  out  1  I2C clock, push-pull
SDA_OE  out  1  1 = drive SDA low, 0 = release (open drain)
BUSY  out  1  high from accept until return to IDLE
DONE  out  1  one-cycle pulse at end of transaction
ACK_ERR  out  1  NACK seen in last transaction; valid with DONE, held until next accept

Behaviour:
- Reset values: SCL=1, SDA_OE=0, BUSY=0, DONE=0, ACK_ERR=0; state=IDLE; tick counter=0. Reset mid-transaction aborts immediately and the bus is released on the next cycle. No STOP is generated.
- Tick counter: width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 only while not IDLE. qtick=1 when count==CLK_DIV-1, and the count then wraps to 0. The counter is held at 0 in IDLE.
- Each bit slot has 4 phases (p0..p3), advancing on qtick.
- Data/ACK slot: SCL is 0 in p0-p1 and 1 in p2-p3. SDA changes only at entry to p0. SDA_IN is sampled on the qtick that ends p2.
- States and slots:
  - IDLE: waits for START.
  - STRT: SCL=1 throughout; SDA released in p0-p1, driven low in p2-p3.
  - ADDR: 8 slots sending {ADDR,1'b0}, MSB first.
  - AACK: 1 slot, SDA released; SDA_IN sampled.
  - DATA: 8 slots sending DATA, MSB first.
  - DACK: 1 slot, SDA released; SDA_IN sampled.
  - STOP: SCL=0 in p0, SCL=1 in p1-p3; SDA low in p0-p1, released in p2-p3.
- Bit value mapping: a bit value of 1 gives SDA_OE=0; a bit value of 0 gives SDA_OE=1.
- Transitions:
  - IDLE->STRT when START=1. The accept cycle latches ADDR/DATA, sets BUSY and clears ACK_ERR.
  - STRT->ADDR after 4 qticks.
  - ADDR->AACK after 8 slots (3-bit bit index, counting 7 down to 0).
  - AACK->DATA if the sample is 0 (ACK). If the sample is 1 (NACK), go AACK->STOP and set ACK_ERR; the data byte is not sent.
  - DATA->DACK after 8 slots.
  - DACK->STOP. A sample of 1 sets ACK_ERR.
  - STOP->IDLE on the final qtick. DONE=1 in the first IDLE cycle and BUSY=0 in that same cycle.
- Latency: START at edge N gives BUSY=1 from N+1.
  - Full transaction: 80 quarters, so DONE occurs 80*CLK_DIV+1 cycles after accept.
  - Address NACK: 44 quarters.
- START while BUSY is ignored, with no queuing. START in the DONE cycle is accepted, so back-to-back transactions are legal.
- No clock stretching and no arbitration loss. SDA_IN is read only in ACK slots.
- SDA_IN arrives already synchronised externally.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, STRT, ADDR, AACK, DATA, DACK, STOP);
  - phase constants P0..P3;
  - the R/W bit constant I2C_WR=1'b0.
- Natural sub-module: i2c_qtick, a parameterised quarter-period counter with an enable input and qtick output. It replaces free-running division.

Test Plan:
1. CLK_DIV=4, ADDR=0x50, DATA=0xA5, SDA_IN=0 during ACKs:
   - SDA bits on SCL rising edges are 1010000,0,[ack],10100101,[ack];
   - START condition precedes, STOP follows;
   - DONE is seen 321 cycles after accept, with ACK_ERR=0.
2. Same as scenario 1, but SDA_IN=1 in the AACK slot:
   - no data slots are sent; STOP follows;
   - DONE comes 177 cycles after accept, with ACK_ERR=1.
3. SDA_IN=1 only in the DACK slot:
   - all 8 data bits are sent;
   - DONE at 321 cycles, with ACK_ERR=1; ACK_ERR clears on the next accept.
4. Second START pulsed mid-transaction (cycle 100):
   - ignored; only one DONE; BUSY stays continuously high.
5. START held high through the DONE cycle:
   - a second transaction starts on that edge;
   - BUSY is low for exactly 1 cycle; both transactions are complete and correct.
6. RESET asserted during DATA, bit 3:
   - the next cycle shows SCL=1, SDA_OE=0, BUSY=0, DONE=0, ACK_ERR=0;
   - a subsequent START runs a clean full transaction.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C write sequencer: state encoding,
// quarter-phase names and the per-state SCL/SDA drive table.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STRT,
        ADDR,
        AACK,
        DATA,
        DACK,
        STOP
    } i2c_state_e;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam logic I2C_WR = 1'b0;

    // Returns {scl, sda_oe} for a given state, quarter phase and current bit.
    function automatic logic [1:0] bus_drive(input i2c_state_e st,
                                             input logic [1:0] ph,
                                             input logic       bitv);
        logic scl;
        logic oe;
        scl = 1'b1;
        oe  = 1'b0;
        case (st)
            STRT: oe = (ph >= P2);
            ADDR, DATA: begin
                scl = (ph >= P2);
                oe  = ~bitv;
            end
            AACK, DACK: scl = (ph >= P2);
            STOP: begin
                scl = (ph != P0);
                oe  = (ph <= P1);
            end
            default: begin
                scl = 1'b1;
                oe  = 1'b0;
            end
        endcase
        return {scl, oe};
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-SCL-period tick generator; held at zero while disabled so every
// transaction starts on a clean quarter boundary.
module i2c_qtick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic REF_CLK,
    input  logic RESET,
    input  logic en,
    output logic qtick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign qtick = en && (count == LAST);

    always_ff @(posedge REF_CLK) begin
        if (RESET || !en) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_write_ctrl.sv
// Single-byte I2C write master: START, addr+W, ACK, data, ACK, STOP.
// SCL/SDA_OE are registered from the next state so the pins never glitch.
module i2c_write_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       REF_CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [6:0] ADDR,
    input  logic [7:0] DATA,
    input  logic       SDA_IN,
    output logic       SCL,
    output logic       SDA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ACK_ERR
);

    i2c_state_e state;
    i2c_state_e nxt_state;
    logic [1:0] phase;
    logic [1:0] nxt_phase;
    logic [2:0] bit_idx;
    logic [2:0] nxt_bit_idx;
    logic [7:0] addr_byte;
    logic [7:0] data_byte;
    logic       nxt_bit;
    logic [1:0] nxt_bus;
    logic       qtick;
    logic       accept;
    logic       finish;
    logic       ack_sample;

    i2c_qtick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .REF_CLK (REF_CLK),
        .RESET   (RESET),
        .en      (state != i2c_pkg::IDLE),
        .qtick   (qtick)
    );

    assign accept     = (state == i2c_pkg::IDLE) && START;
    assign finish     = (state == i2c_pkg::STOP) && qtick && (phase == P3);
    assign ack_sample = qtick && (phase == P2) &&
                        ((state == i2c_pkg::AACK) || (state == i2c_pkg::DACK));

    always_comb begin
        nxt_state   = state;
        nxt_phase   = phase;
        nxt_bit_idx = bit_idx;
        if (accept) begin
            nxt_state = i2c_pkg::STRT;
            nxt_phase = P0;
        end else if (qtick) begin
            nxt_phase = phase + 2'd1;
            if (phase == P3) begin
                case (state)
                    i2c_pkg::STRT: begin
                        nxt_state   = i2c_pkg::ADDR;
                        nxt_bit_idx = 3'd7;
                    end
                    i2c_pkg::ADDR: begin
                        if (bit_idx == 3'd0) nxt_state = i2c_pkg::AACK;
                        else                 nxt_bit_idx = bit_idx - 3'd1;
                    end
                    // ACK_ERR already holds this slot's sample taken at the end of p2.
                    i2c_pkg::AACK: begin
                        if (ACK_ERR) begin
                            nxt_state = i2c_pkg::STOP;
                        end else begin
                            nxt_state   = i2c_pkg::DATA;
                            nxt_bit_idx = 3'd7;
                        end
                    end
                    i2c_pkg::DATA: begin
                        if (bit_idx == 3'd0) nxt_state = i2c_pkg::DACK;
                        else                 nxt_bit_idx = bit_idx - 3'd1;
                    end
                    i2c_pkg::DACK: nxt_state = i2c_pkg::STOP;
                    i2c_pkg::STOP: nxt_state = i2c_pkg::IDLE;
                    default:       nxt_state = i2c_pkg::IDLE;
                endcase
            end
        end
        nxt_bit = (nxt_state == i2c_pkg::ADDR) ? addr_byte[nxt_bit_idx]
                                               : data_byte[nxt_bit_idx];
        nxt_bus = bus_drive(nxt_state, nxt_phase, nxt_bit);
    end

    always_ff @(posedge REF_CLK) begin
        if (RESET) begin
            state     <= i2c_pkg::IDLE;
            phase     <= P0;
            bit_idx   <= 3'd0;
            addr_byte <= 8'd0;
            data_byte <= 8'd0;
            SCL       <= 1'b1;
            SDA_OE    <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ACK_ERR   <= 1'b0;
        end else begin
            state         <= nxt_state;
            phase         <= nxt_phase;
            bit_idx       <= nxt_bit_idx;
            {SCL, SDA_OE} <= nxt_bus;
            DONE          <= finish;
            if (accept) begin
                addr_byte <= {ADDR, I2C_WR};
                data_byte <= DATA;
                BUSY      <= 1'b1;
                ACK_ERR   <= 1'b0;
            end else begin
                if (finish) BUSY <= 1'b0;
                if (ack_sample && SDA_IN) ACK_ERR <= 1'b1;
            end
        end
    end

endmodule
